// File: rtl/mem_axi_rd_ctrl.sv
// AXI4 read-channel slave front-end for the simple dual-port RAM read port.
// Splits each AR burst into per-beat RAM reads, absorbs the 1-cycle RAM read
// latency and returns R beats through a 2-entry buffer with full RREADY back-pressure.
module mem_axi_rd_ctrl #(
    parameter int unsigned WIDTH_CID = 4,
    parameter int unsigned WIDTH_AD  = 10,
    parameter int unsigned WIDTH_DA  = 32,
    parameter int unsigned WIDTH_DS  = WIDTH_DA / 8,
    parameter int unsigned WIDTH_DSB = $clog2(WIDTH_DS)
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [WIDTH_CID-1:0] ARID,
    input  logic [WIDTH_AD-1:0]  ARADDR,
    input  logic [7:0]           ARLEN,
    input  logic [2:0]           ARSIZE,
    input  logic [1:0]           ARBURST,
    input  logic                 ARVALID,
    output logic                 ARREADY,
    output logic [WIDTH_CID-1:0] RID,
    output logic [WIDTH_DA-1:0]  RDATA,
    output logic [1:0]           RRESP,
    output logic                 RLAST,
    output logic                 RVALID,
    input  logic                 RREADY,
    output logic [WIDTH_AD-1:0]  MRADDR,
    output logic [WIDTH_DS-1:0]  MRSTRB,
    output logic                 MREN,
    input  logic [WIDTH_DA-1:0]  MRDATA
);

    localparam logic [2:0] MaxSize    = 3'(WIDTH_DSB);
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] BurstWrap  = 2'b10;
    localparam logic [1:0] BurstRsvd  = 2'b11;

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e               state_q, state_d;
    logic                 arm_q;
    logic [WIDTH_CID-1:0] id_q, id_d;
    logic [WIDTH_AD-1:0]  addr_q, addr_d;
    logic [7:0]           len_q, len_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [2:0]           size_q, size_d;
    logic [1:0]           burst_q, burst_d;
    logic                 illegal_q, illegal_d;

    logic                 inflight_q, inflight_last_q;
    logic [WIDTH_CID-1:0] inflight_id_q;

    logic [WIDTH_DA-1:0]  buf_data_q [2];
    logic [WIDTH_CID-1:0] buf_id_q   [2];
    logic [1:0]           buf_resp_q [2];
    logic                 buf_last_q [2];
    logic                 rd_ptr_q, rd_ptr_d;
    logic                 wr_ptr_q, wr_ptr_d;
    logic [1:0]           occ_q, occ_d;

    logic                 ar_fire, ar_illegal;
    logic                 pop, push, issue, mren, ill_push;
    logic [2:0]           level;
    logic [WIDTH_AD-1:0]  sz, wrap_mask, addr_next;
    logic [WIDTH_DS-1:0]  strb;
    int unsigned          lane_lo, lane_sz, lane_base;

    logic [WIDTH_DA-1:0]  push_data;
    logic [WIDTH_CID-1:0] push_id;
    logic [1:0]           push_resp;
    logic                 push_last;

    assign ARREADY = (state_q == StIdle) && arm_q;
    assign ar_fire = ARVALID && ARREADY;

    // Legality of the incoming burst, decided once at AR acceptance
    always_comb begin
        ar_illegal = 1'b0;
        if (ARSIZE > MaxSize) ar_illegal = 1'b1;
        if (ARBURST == BurstRsvd) ar_illegal = 1'b1;
        if ((ARBURST == BurstWrap) &&
            !((ARLEN == 8'd1) || (ARLEN == 8'd3) || (ARLEN == 8'd7) || (ARLEN == 8'd15))) begin
            ar_illegal = 1'b1;
        end
    end

    // Issue gating: entries held + read in flight - entry leaving must leave room for one more
    always_comb begin
        pop      = (occ_q != 2'd0) && RREADY;
        level    = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue    = (state_q == StBurst) && (level < 3'd2);
        mren     = issue && !illegal_q;
        ill_push = issue && illegal_q;
        push     = inflight_q || ill_push;
    end

    // Next beat address for the latched burst type
    always_comb begin
        sz        = WIDTH_AD'(1) << size_q;
        wrap_mask = ((WIDTH_AD'(len_q) + WIDTH_AD'(1)) << size_q) - WIDTH_AD'(1);
        case (burst_q)
            BurstFixed: addr_next = addr_q;
            // Later INCR beats are aligned even if the first one was not
            BurstIncr:  addr_next = (addr_q & ~(sz - WIDTH_AD'(1))) + sz;
            BurstWrap:  addr_next = (addr_q & ~wrap_mask) | ((addr_q + sz) & wrap_mask);
            default:    addr_next = addr_q;
        endcase
    end

    // Byte lanes from the beat address up to the end of its size-aligned slot
    always_comb begin
        lane_sz   = 32'd1 << size_q;
        lane_lo   = 32'(addr_q[WIDTH_DSB-1:0]);
        lane_base = lane_lo & ~(lane_sz - 32'd1);
        strb      = '0;
        for (int unsigned i = 0; i < WIDTH_DS; i++) begin
            strb[i] = mren && (i >= lane_lo) && (i < lane_base + lane_sz);
        end
    end

    assign MREN   = mren;
    assign MRADDR = mren ? addr_q : '0;
    assign MRSTRB = strb;

    // Burst FSM next state: accept AR in idle, walk the beat counter in burst
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        size_d    = size_q;
        burst_d   = burst_q;
        illegal_d = illegal_q;
        case (state_q)
            StIdle: begin
                if (ar_fire) begin
                    id_d      = ARID;
                    addr_d    = ARADDR;
                    len_d     = ARLEN;
                    cnt_d     = ARLEN;
                    size_d    = ARSIZE;
                    burst_d   = ARBURST;
                    illegal_d = ar_illegal;
                    state_d   = StBurst;
                end
            end
            StBurst: begin
                if (issue) begin
                    if (cnt_q == 8'd0) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d  = cnt_q - 8'd1;
                        addr_d = addr_next;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Burst FSM and burst context registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= StIdle;
            arm_q     <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            arm_q     <= 1'b1;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            illegal_q <= illegal_d;
        end
    end

    // Remember what the RAM read issued this cycle belongs to
    always_ff @(posedge CLK) begin
        if (RESET) begin
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            inflight_id_q   <= '0;
        end else begin
            inflight_q      <= mren;
            inflight_last_q <= (cnt_q == 8'd0);
            inflight_id_q   <= id_q;
        end
    end

    // Buffer entry source: RAM data for a returning read, else an error beat
    always_comb begin
        if (inflight_q) begin
            push_data = MRDATA;
            push_id   = inflight_id_q;
            push_resp = RespOkay;
            push_last = inflight_last_q;
        end else begin
            push_data = '0;
            push_id   = id_q;
            push_resp = RespSlvErr;
            push_last = (cnt_q == 8'd0);
        end
        wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = pop ? ~rd_ptr_q : rd_ptr_q;
        occ_d    = occ_q + {1'b0, push} - {1'b0, pop};
    end

    // Two-entry R buffer storage and pointers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
                buf_id_q[i]   <= '0;
                buf_resp_q[i] <= '0;
                buf_last_q[i] <= 1'b0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push) begin
                buf_data_q[wr_ptr_q] <= push_data;
                buf_id_q[wr_ptr_q]   <= push_id;
                buf_resp_q[wr_ptr_q] <= push_resp;
                buf_last_q[wr_ptr_q] <= push_last;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign RVALID = (occ_q != 2'd0);
    assign RDATA  = RVALID ? buf_data_q[rd_ptr_q] : '0;
    assign RID    = RVALID ? buf_id_q[rd_ptr_q] : '0;
    assign RRESP  = RVALID ? buf_resp_q[rd_ptr_q] : '0;
    assign RLAST  = RVALID && buf_last_q[rd_ptr_q];

endmodule

// File: tb/tb_mem_axi_rd_ctrl.sv
// Bench for mem_axi_rd_ctrl: directed bursts plus random bursts with random
// RREADY, checked against a per-beat reference computed from the burst rules.
module tb_mem_axi_rd_ctrl;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    typedef struct packed {
        logic [9:0] addr;
        logic [3:0] strb;
    } rd_t;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [3:0]  ARID = '0;
    logic [9:0]  ARADDR = '0;
    logic [7:0]  ARLEN = '0;
    logic [2:0]  ARSIZE = '0;
    logic [1:0]  ARBURST = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY = 1'b0;
    logic [9:0]  MRADDR;
    logic [3:0]  MRSTRB;
    logic        MREN;
    logic [31:0] MRDATA;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    rbeat_t exp_r[$];
    rd_t    exp_rd[$];
    int     outstanding = 0;
    int     pop_cnt = 0;
    int     mren_cnt = 0;
    int     first_rv = -1;
    int     first_mren = -1;
    int     last_mren = -1;
    int     hs_last = -1;
    int     hs_prev = -1;
    bit     held = 0;
    logic [38:0] held_beat = '0;

    int rr_pct = 100;
    int rr_low = 0;

    logic [31:0] ram [256];
    logic [31:0] ram_rdata = '0;

    int wrap_lens[4] = '{1, 3, 7, 15};
    logic [3:0] t_id;
    logic [9:0] t_addr;
    logic [7:0] t_len;
    logic [2:0] t_size;
    logic [1:0] t_burst;

    assign MRDATA = ram_rdata;

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    mem_axi_rd_ctrl #(
        .WIDTH_CID(4),
        .WIDTH_AD (10),
        .WIDTH_DA (32),
        .WIDTH_DS (4),
        .WIDTH_DSB(2)
    ) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .ARID   (ARID),
        .ARADDR (ARADDR),
        .ARLEN  (ARLEN),
        .ARSIZE (ARSIZE),
        .ARBURST(ARBURST),
        .ARVALID(ARVALID),
        .ARREADY(ARREADY),
        .RID    (RID),
        .RDATA  (RDATA),
        .RRESP  (RRESP),
        .RLAST  (RLAST),
        .RVALID (RVALID),
        .RREADY (RREADY),
        .MRADDR (MRADDR),
        .MRSTRB (MRSTRB),
        .MREN   (MREN),
        .MRDATA (MRDATA)
    );

    // RAM read port model with 1-cycle latency
    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'hA000_0000 + 32'(i);
    end
    always @(posedge CLK) begin
        if (MREN) ram_rdata <= ram[MRADDR[9:2]];
    end

    // RREADY driver: forced-low window first, otherwise random with rr_pct percent high
    always @(posedge CLK) begin
        #2;
        if (rr_low > 0) begin
            RREADY = 1'b0;
            rr_low--;
        end else begin
            RREADY = ($urandom_range(99) < rr_pct);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: expand one accepted AR into its RAM reads and R beats
    task automatic model_ar(input logic [3:0] id, input logic [9:0] a0, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        int     sz, total, base, a, a0i, beats;
        bit     bad;
        rbeat_t b;
        rd_t    r;
        sz    = 1 << size;
        a0i   = int'(a0);
        beats = int'(len) + 1;
        bad   = (size > 3'd2) || (burst == 2'd3) ||
                (burst == 2'd2 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
        total = sz * beats;
        base  = a0i - (a0i % total);
        for (int n = 0; n < beats; n++) begin
            b.id   = id;
            b.last = (n == beats - 1);
            if (bad) begin
                b.data = 32'h0;
                b.resp = 2'd2;
            end else begin
                case (burst)
                    2'd0:    a = a0i;
                    2'd1:    a = (a0i + n * sz) % 1024;
                    default: a = base + ((a0i - base + n * sz) % total);
                endcase
                r.addr = 10'(a);
                r.strb = 4'(((1 << sz) - 1) << (a % 4));
                exp_rd.push_back(r);
                b.data = 32'hA000_0000 + 32'(a / 4);
                b.resp = 2'd0;
            end
            exp_r.push_back(b);
        end
    endtask

    // Monitor: samples mid-cycle, consumes reference entries on each handshake
    always @(negedge CLK) begin
        rbeat_t e;
        rd_t    r;
        if (RESET) begin
            exp_r.delete();
            exp_rd.delete();
            outstanding = 0;
            held = 0;
        end else begin
            if (held) begin
                check_eq("hold_rvalid", RVALID, 1);
                check_eq("hold_beat", {RID, RDATA, RRESP, RLAST}, held_beat);
            end
            held      = RVALID && !RREADY;
            held_beat = {RID, RDATA, RRESP, RLAST};
            if (RVALID && first_rv < 0) first_rv = cyc;
            if (RVALID && RREADY) begin
                pop_cnt++;
                if (exp_r.size() == 0) begin
                    check_eq("r_unexpected", RVALID, 0);
                end else begin
                    e = exp_r.pop_front();
                    check_eq("r_id", RID, e.id);
                    check_eq("r_data", RDATA, e.data);
                    check_eq("r_resp", RRESP, e.resp);
                    check_eq("r_last", RLAST, e.last);
                    if (e.resp == 2'd0) outstanding--;
                end
            end
            if (MREN) begin
                mren_cnt++;
                if (first_mren < 0) first_mren = cyc;
                last_mren = cyc;
                if (exp_rd.size() == 0) begin
                    check_eq("mren_unexpected", MREN, 0);
                end else begin
                    r = exp_rd.pop_front();
                    check_eq("mraddr", MRADDR, r.addr);
                    check_eq("mrstrb", MRSTRB, r.strb);
                    outstanding++;
                    check_eq("outstanding_le2", outstanding <= 2, 1);
                end
            end
            if (ARVALID && ARREADY) begin
                hs_prev = hs_last;
                hs_last = cyc + 1;
                model_ar(ARID, ARADDR, ARLEN, ARSIZE, ARBURST);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [9:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        ARID    = id;
        ARADDR  = addr;
        ARLEN   = len;
        ARSIZE  = size;
        ARBURST = burst;
        ARVALID = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (ARREADY) break;
        end
        check_eq("arready", ARREADY, 1);
        tick();
        ARVALID = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while ((exp_r.size() != 0 || exp_rd.size() != 0) && n < max_cyc) begin
            tick();
            n++;
        end
        check_eq("drain_pending", exp_r.size() + exp_rd.size(), 0);
        repeat (3) tick();
    endtask

    task automatic clear_stats();
        pop_cnt    = 0;
        mren_cnt   = 0;
        first_rv   = -1;
        first_mren = -1;
        last_mren  = -1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        // Reset state
        check_eq("rst_arready", ARREADY, 0);
        check_eq("rst_rvalid", RVALID, 0);
        check_eq("rst_mren", MREN, 0);
        check_eq("rst_r_fields", {RID, RDATA, RRESP, RLAST}, 0);
        check_eq("rst_m_fields", {MRADDR, MRSTRB}, 0);
        RESET = 1'b0;
        tick();
        tick();
        check_eq("post_rst_arready", ARREADY, 1);

        // INCR 0x10 len 3 size 2 with RREADY high: timing and data
        rr_pct = 100;
        clear_stats();
        send_ar(4'd3, 10'h010, 8'd3, 3'd2, 2'd1);
        drain(100);
        check_eq("t1_first_mren", first_mren - hs_last, 0);
        check_eq("t1_mren_span", last_mren - first_mren, 3);
        check_eq("t1_rvalid_lat", first_rv - hs_last, 2);
        check_eq("t1_beats", pop_cnt, 4);

        // Same burst with RREADY low for 5 cycles after the first RVALID
        clear_stats();
        send_ar(4'd4, 10'h010, 8'd3, 3'd2, 2'd1);
        for (int i = 0; i < 20 && !RVALID; i++) tick();
        check_eq("t2_rvalid_seen", RVALID, 1);
        rr_low = 5;
        drain(100);
        check_eq("t2_beats", pop_cnt, 4);
        check_eq("t2_mren", mren_cnt, 4);

        // WRAP and FIXED address sequences
        send_ar(4'd5, 10'h038, 8'd3, 3'd2, 2'd2);
        drain(100);
        send_ar(4'd6, 10'h020, 8'd2, 3'd2, 2'd0);
        drain(100);

        // Illegal bursts: oversize and reserved type
        clear_stats();
        send_ar(4'd7, 10'h040, 8'd0, 3'd3, 2'd1);
        drain(100);
        send_ar(4'd8, 10'h044, 8'd1, 3'd2, 2'd3);
        drain(100);
        check_eq("t4_no_mren", mren_cnt, 0);
        check_eq("t4_beats", pop_cnt, 3);

        // Back-to-back ARs
        clear_stats();
        send_ar(4'd1, 10'h100, 8'd1, 3'd2, 2'd1);
        send_ar(4'd2, 10'h200, 8'd2, 3'd2, 2'd1);
        check_eq("t5_ar_gap_le3", (hs_last - hs_prev) <= 3, 1);
        drain(100);
        check_eq("t5_beats", pop_cnt, 5);

        // Reset one cycle after the 2nd beat of a len 7 burst
        clear_stats();
        send_ar(4'd9, 10'h080, 8'd7, 3'd2, 2'd1);
        for (int i = 0; i < 30 && pop_cnt < 2; i++) tick();
        check_eq("t6_two_beats", pop_cnt, 2);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        @(negedge CLK);
        #1;
        check_eq("t6_rvalid", RVALID, 0);
        check_eq("t6_mren", MREN, 0);
        check_eq("t6_arready_low", ARREADY, 0);
        tick();
        check_eq("t6_arready", ARREADY, 1);
        clear_stats();
        send_ar(4'd10, 10'h0C0, 8'd0, 3'd2, 2'd1);
        drain(100);
        check_eq("t6_new_beats", pop_cnt, 1);

        // Random bursts with random back-pressure
        rr_pct = 60;
        for (int t = 0; t < 40; t++) begin
            t_id    = 4'($urandom_range(15));
            t_size  = ($urandom_range(9) == 0) ? 3'd3 : 3'($urandom_range(2));
            t_burst = ($urandom_range(9) == 0) ? 2'd3 : 2'($urandom_range(2));
            if (t_burst == 2'd2 && $urandom_range(7) != 0) begin
                t_len = 8'(wrap_lens[$urandom_range(3)]);
            end else begin
                t_len = 8'($urandom_range(15));
            end
            t_addr = 10'($urandom_range(1023));
            if (t_size <= 3'd2) t_addr = t_addr & ~(10'((1 << t_size) - 1));
            repeat ($urandom_range(3)) tick();
            send_ar(t_id, t_addr, t_len, t_size, t_burst);
        end
        drain(3000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_axi_rd_ctrl.md
Name: mem_axi_rd_ctrl

Overview:
AXI4 read-channel slave front-end that feeds the read port (RADDR/REN/RSTRB in, RDATA out) of the team's synchronous simple dual-port RAM. It turns one AR burst into a sequence of per-beat RAM reads, absorbs the RAM's 1-cycle read latency, and returns R beats with full RREADY back-pressure through a 2-entry buffer. A separate write-channel controller drives the RAM write port; this block does not interact with it.

Parameters:
WIDTH_CID, 4, AXI ID width
WIDTH_AD, 10, byte-address width (memory size 1<<WIDTH_AD bytes)
WIDTH_DA, 32, data width in bits
WIDTH_DS, WIDTH_DA/8, bytes per line
WIDTH_DSB, clogb2(WIDTH_DS), log2 of bytes per line

Ports:
CLK  input  1  clock, all logic on rising edge
RESET  input  1  synchronous, active-high reset
ARID  input  WIDTH_CID  read-burst ID
ARADDR  input  WIDTH_AD  start byte address
ARLEN  input  8  beats minus 1
ARSIZE  input  3  log2 bytes per beat
ARBURST  input  2  0=FIXED, 1=INCR, 2=WRAP, 3=reserved
ARVALID  input  1  AR valid
ARREADY  output  1  AR ready
RID  output  WIDTH_CID  beat ID
RDATA  output  WIDTH_DA  beat data
RRESP  output  2  0=OKAY, 2=SLVERR
RLAST  output  1  final beat of the burst
RVALID  output  1  R valid
RREADY  input  1  R ready
MRADDR  output  WIDTH_AD  RAM read byte address
MRSTRB  output  WIDTH_DS  RAM read byte lanes
MREN  output  1  RAM read enable
MRDATA  input  WIDTH_DA  RAM read data, valid the cycle after MREN

Behaviour:
- Reset (RESET=1 at an edge): FSM->IDLE; buffer flushed; in-flight read discarded. ARREADY, RVALID, RLAST, MREN=0; RID, RDATA, RRESP, MRADDR, MRSTRB=0. A reset mid-burst aborts the burst; no further beats are issued.
- FSM states:
  - IDLE: ARREADY=1. ARVALID&ARREADY latches ID, addr, len, size, burst; beat counter=ARLEN; ->BURST.
  - BURST: ARREADY=0; issues reads. After the last beat is issued, ->IDLE. The next AR may then be accepted while earlier beats are still draining.
- MREN, MRADDR, MRSTRB are combinational from registered state.
  - MREN=1 in BURST when the burst is legal and occ + inflight - pop < 2.
  - occ = buffer entries; inflight = MREN of the previous cycle; pop = RVALID&RREADY.
  - Gives 1 beat/cycle sustained when RREADY=1.
- Capture: the cycle after MREN=1, MRDATA is pushed into the buffer with ID, RRESP=OKAY, and last = (counter was 0 at issue).
- Latency: AR handshake at edge k -> MREN=1 during cycle k+1 -> RVALID=1 after edge k+2.
- Address per beat, with sz=1<<size:
  - FIXED: unchanged.
  - INCR: addr+sz, modulo 2^WIDTH_AD.
  - WRAP: mask=sz*(len+1)-1; next=(addr&~mask)|((addr+sz)&mask). Legal len is 1, 3, 7 or 15.
- MRSTRB sets sz lanes starting at lane addr[WIDTH_DSB-1:0] aligned down to sz. The first unaligned INCR beat enables lanes from addr to the beat boundary; later beats are aligned.
- RDATA carries the full line; the master selects lanes.
- Illegal burst: ARSIZE>WIDTH_DSB, ARBURST=3, or WRAP with illegal len.
  - MREN is never asserted.
  - len+1 beats are returned with RRESP=SLVERR, RDATA=0, correct RID, and RLAST on the final beat.
  - One beat is pushed per cycle while the buffer has space.
- R channel: RVALID stays high until RREADY; RDATA/RID/RRESP/RLAST stay stable while RVALID&!RREADY. The buffer never overflows; pop and push in the same cycle are allowed.
- Buffer full (occ=2, RREADY=0): MREN=0 and the counter is held.

Test Plan:
- RAM line i preloaded = 0xA0000000+i. AR INCR addr 0x10, len 3, size 2, RREADY=1 -> MRADDR 0x10,0x14,0x18,0x1C on consecutive cycles; RDATA 0xA0000004..7; RLAST on beat 4 only; first RVALID 2 cycles after AR handshake.
- Same burst, RREADY low 5 cycles after the first RVALID -> MREN stops with occ=2; RDATA held stable; all 4 beats delivered in order with no loss or duplication.
- WRAP addr 0x38, len 3, size 2 -> MRADDR 0x38,0x3C,0x30,0x34. FIXED addr 0x20, len 2 -> 0x20 three times.
- INCR len 0, size 3 on 32-bit -> one beat, RRESP=SLVERR, RDATA=0, RLAST=1, MREN never asserted. ARBURST=3, len 1 -> two SLVERR beats.
- Back-to-back ARs ID 1 (len 1) and ID 2 (len 2) -> second ARREADY within 3 cycles of the first; beats in order with RID 1,1,2,2,2; RLAST on beats 2 and 5.
- RESET pulsed 1 cycle after the 2nd beat of a len 7 burst -> RVALID=0 and MREN=0 the next cycle; ARREADY=1 the cycle after; a new len 0 burst then completes normally.
